// File: rtl/rtc_bus_seq.sv
// Multiplexed-bus access sequencer: a read burst over an address table or a single write,
// stepping through address, turnaround, data-strobe and recovery phases with registered outputs.
module rtc_bus_seq #(
  parameter int N_REG  = 10,
  parameter int T_ADDR = 6,
  parameter int T_TURN = 18,
  parameter int T_DATA = 9,
  parameter int T_GAP  = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  input  logic [8*N_REG-1:0] addr_tab,
  input  logic [3:0]         wr_idx,
  input  logic [7:0]         wdata,
  input  logic [7:0]         ADin,
  output logic [7:0]         ADout,
  output logic               ad,
  output logic               cs,
  output logic               wr,
  output logic               rd,
  output logic               bus_rel,
  output logic [8*N_REG-1:0] rdata,
  output logic               rd_valid,
  output logic [3:0]         rd_idx,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AEND, S_TURN, S_DATA, S_DEND, S_GAP
  } st_t;

  localparam logic [7:0] C_ADDR   = 8'(T_ADDR - 1);
  localparam logic [7:0] C_TURN   = 8'(T_TURN - 1);
  localparam logic [7:0] C_DATA   = 8'(T_DATA - 1);
  localparam logic [7:0] C_GAP    = 8'(T_GAP - 1);
  localparam logic [4:0] LAST_IDX = 5'(N_REG - 1);
  localparam logic [4:0] NREG5    = 5'(N_REG);

  st_t        st;
  logic [7:0] cnt;
  logic [3:0] idx;
  logic       wmode;

  assign state = st;

  function automatic logic [7:0] addr_of(input logic [8*N_REG-1:0] tab, input logic [3:0] i);
    logic [7:0] a;
    a = 8'hFF;
    for (int k = 0; k < N_REG; k++)
      if (i == 4'(k)) a = tab[8*k +: 8];
    return a;
  endfunction

  // Handshake: start is a level request taken only in IDLE (ignored while busy); abort ends any
  // active access on the next edge, beats phase advance, and is a no-op in IDLE; reset beats both.
  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      wmode    <= 1'b0;
      ADout    <= 8'hFF;
      ad       <= 1'b1;
      cs       <= 1'b1;
      wr       <= 1'b1;
      rd       <= 1'b1;
      bus_rel  <= 1'b0;
      rdata    <= '0;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      if (abort && st != S_IDLE) begin
        st      <= S_IDLE;
        cnt     <= '0;
        busy    <= 1'b0;
        ADout   <= 8'hFF;
        ad      <= 1'b1;
        cs      <= 1'b1;
        wr      <= 1'b1;
        rd      <= 1'b1;
        bus_rel <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            if (start && !abort) begin
              if (!mode || ({1'b0, wr_idx} < NREG5)) begin
                st      <= S_ADDR;
                cnt     <= C_ADDR;
                idx     <= mode ? wr_idx : 4'd0;
                wmode   <= mode;
                busy    <= 1'b1;
                ADout   <= addr_of(addr_tab, mode ? wr_idx : 4'd0);
                ad      <= 1'b0;
                cs      <= 1'b0;
                wr      <= 1'b0;
                rd      <= 1'b1;
                bus_rel <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_ADDR: begin
            if (cnt != 8'd0) cnt <= cnt - 8'd1;
            else begin
              st <= S_AEND;
              ad <= 1'b1;
              cs <= 1'b1;
              wr <= 1'b1;
            end
          end
          S_AEND: begin
            st      <= S_TURN;
            cnt     <= C_TURN;
            ADout   <= 8'hFF;
            bus_rel <= 1'b1;
          end
          S_TURN: begin
            if (cnt != 8'd0) cnt <= cnt - 8'd1;
            else begin
              st  <= S_DATA;
              cnt <= C_DATA;
              cs  <= 1'b0;
              if (wmode) begin
                wr      <= 1'b0;
                bus_rel <= 1'b0;
                ADout   <= wdata;
              end else begin
                rd <= 1'b0;
              end
            end
          end
          S_DATA: begin
            if (cnt != 8'd0) cnt <= cnt - 8'd1;
            else begin
              st      <= S_DEND;
              cs      <= 1'b1;
              wr      <= 1'b1;
              rd      <= 1'b1;
              ADout   <= 8'hFF;
              bus_rel <= 1'b0;
              // The device's data is taken on the final strobe cycle, reported one cycle later.
              if (!wmode) begin
                for (int k = 0; k < N_REG; k++)
                  if (idx == 4'(k)) rdata[8*k +: 8] <= ADin;
                rd_valid <= 1'b1;
                rd_idx   <= idx;
              end
            end
          end
          S_DEND: begin
            st  <= S_GAP;
            cnt <= C_GAP;
          end
          S_GAP: begin
            if (cnt != 8'd0) cnt <= cnt - 8'd1;
            else if (!wmode && ({1'b0, idx} < LAST_IDX)) begin
              st    <= S_ADDR;
              cnt   <= C_ADDR;
              idx   <= idx + 4'd1;
              ADout <= addr_of(addr_tab, idx + 4'd1);
              ad    <= 1'b0;
              cs    <= 1'b0;
              wr    <= 1'b0;
            end else begin
              st   <= S_IDLE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Bench for rtc_bus_seq: vector table plus random transactions against a cycle-offset model,
// and hand sequences for reset mid-burst, restart after done and a single-register minimal-timing build.
module tb_rtc_bus_seq;

  localparam int N_REG = 10;
  localparam int TA = 6;
  localparam int TT = 18;
  localparam int TD = 9;
  localparam int TG = 10;
  localparam int P  = TA + TT + TD + TG + 2;

  typedef struct {
    logic       mode;
    logic [3:0] wr_idx;
    logic [7:0] wdata;
    int         abort_at;
    int         hold;
    logic       fixed;
    int         exp_done;
    int         exp_err;
    int         exp_nrd;
  } vec_t;

  logic clock = 1'b0;
  logic reset, start, start1, mode, abort;
  logic [8*N_REG-1:0] addr_tab;
  logic [3:0] wr_idx;
  logic [7:0] wdata, ADin;

  logic [7:0] ADout;
  logic ad, cs, wr, rd, bus_rel, rd_valid, busy, done, err;
  logic [8*N_REG-1:0] rdata;
  logic [3:0] rd_idx;
  logic [2:0] state;

  logic [7:0] ADout1, rdata1;
  logic ad1, cs1, wr1, rd1, bus_rel1, rd_valid1, busy1, done1, err1;
  logic [3:0] rd_idx1;
  logic [2:0] state1;

  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];
  logic [7:0] model_rdata [N_REG];
  vec_t vecs[$];

  logic [8:0] single_tab [8] = '{9'b000101000, 9'b111101000, 9'b111111000, 9'b101011000,
                                 9'b111101001, 9'b111101000, 9'b111100100, 9'b111100000};

  rtc_bus_seq #(.N_REG(N_REG), .T_ADDR(TA), .T_TURN(TT), .T_DATA(TD), .T_GAP(TG)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .addr_tab(addr_tab), .wr_idx(wr_idx), .wdata(wdata), .ADin(ADin),
    .ADout(ADout), .ad(ad), .cs(cs), .wr(wr), .rd(rd), .bus_rel(bus_rel),
    .rdata(rdata), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .busy(busy), .done(done), .err(err), .state(state)
  );

  rtc_bus_seq #(.N_REG(1), .T_ADDR(1), .T_TURN(1), .T_DATA(1), .T_GAP(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .mode(mode), .abort(abort),
    .addr_tab(addr_tab[7:0]), .wr_idx(wr_idx), .wdata(wdata), .ADin(ADin),
    .ADout(ADout1), .ad(ad1), .cs(cs1), .wr(wr1), .rd(rd1), .bus_rel(bus_rel1),
    .rdata(rdata1), .rd_valid(rd_valid1), .rd_idx(rd_idx1),
    .busy(busy1), .done(done1), .err(err1), .state(state1)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < N_REG; i++) model_rdata[i] = 8'h00;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " main"}, 128'({ADout, ad, cs, wr, rd, bus_rel, busy, done, err, rd_valid, rd_idx, state}),
          128'({8'hFF, 4'b1111, 5'b00000, 4'h0, 3'h0}));
    check({tag, " rdata"}, 128'(rdata), 128'(0));
    check({tag, " single"}, 128'({ADout1, ad1, cs1, wr1, rd1, bus_rel1, busy1, done1, err1, rd_valid1, rd_idx1, state1, rdata1}),
          128'({8'hFF, 4'b1111, 5'b00000, 4'h0, 3'h0, 8'h00}));
  endtask

  // driver + per-cycle reference model for one transaction started at cycle 0
  task automatic run_txn(input vec_t v, input string tag);
    int nacc, span, ncheck, k, o, idx;
    int dn_cyc, dn_cnt, er_cnt, rd_cnt, m_dn, m_er, m_rd;
    logic err_case, has_txn, act, e_done, e_err, e_rdv, e_ad, e_cs, e_wr, e_rd, e_br;
    logic [7:0] e_out, prev_adin;
    logic [11:0] want;
    logic [8*N_REG-1:0] e_rdata;
    mode = v.mode; wr_idx = v.wr_idx; wdata = v.wdata;
    for (int i = 0; i < N_REG; i++)
      addr_tab[8*i +: 8] = v.fixed ? 8'(8'h20 + i) : 8'($urandom_range(0, 255));
    err_case = v.mode && (int'(v.wr_idx) >= N_REG);
    has_txn = !err_case && (v.abort_at != 0);
    nacc = v.mode ? 1 : N_REG;
    span = nacc * P;
    ncheck = span + 3;
    dn_cyc = 0; dn_cnt = 0; er_cnt = 0; rd_cnt = 0; m_dn = 0; m_er = 0; m_rd = 0; k = 0;
    @(posedge clock);
    #1 start = 1'b1; abort = (v.abort_at == 0); ADin = 8'($urandom_range(0, 255));
    prev_adin = ADin;
    for (int c = 1; c <= ncheck; c++) begin
      @(posedge clock);
      #1;
      start = (c <= v.hold);
      abort = (c == v.abort_at);
      ADin = v.fixed ? 8'(8'h12 + (c - 1) / P) : 8'($urandom_range(0, 255));
      @(negedge clock);
      act = has_txn && (c <= span) && (v.abort_at < 0 || c <= v.abort_at);
      e_out = 8'hFF; e_ad = 1'b1; e_cs = 1'b1; e_wr = 1'b1; e_rd = 1'b1; e_br = 1'b0; e_rdv = 1'b0;
      if (act) begin
        k = (c - 1) / P;
        o = (c - 1) % P;
        idx = v.mode ? int'(v.wr_idx) : k;
        if (o < TA) begin
          e_out = addr_tab[8*idx +: 8]; e_ad = 1'b0; e_cs = 1'b0; e_wr = 1'b0;
        end else if (o == TA) begin
          e_out = addr_tab[8*idx +: 8];
        end else if (o < TA + 1 + TT) begin
          e_br = 1'b1;
        end else if (o < TA + 1 + TT + TD) begin
          e_cs = 1'b0;
          if (v.mode) begin e_wr = 1'b0; e_out = v.wdata; end
          else begin e_rd = 1'b0; e_br = 1'b1; end
        end else if (o == TA + 1 + TT + TD) begin
          e_rdv = !v.mode;
        end
      end
      e_done = has_txn && (c == span + 1) && (v.abort_at < 0 || v.abort_at > span);
      e_err = err_case && (v.abort_at != 0) && (c == 1);
      if (e_rdv) begin
        model_rdata[k] = prev_adin;
        exp_q.push_back({4'(k), prev_adin});
        m_rd++;
      end
      if (e_done) m_dn++;
      if (e_err) m_er++;
      check($sformatf("%s c%0d outs", tag, c),
            128'({ADout, ad, cs, wr, rd, bus_rel, busy, done, err, rd_valid, state != 3'd0}),
            128'({e_out, e_ad, e_cs, e_wr, e_rd, e_br, act, e_done, e_err, e_rdv, act}));
      if (rd_valid) begin
        rd_cnt++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        check($sformatf("%s c%0d rd_sample", tag, c), 128'({rd_idx, rdata[8*int'(rd_idx) +: 8]}), 128'(want));
      end
      if (done) begin dn_cnt++; if (dn_cyc == 0) dn_cyc = c; end
      if (err) er_cnt++;
      prev_adin = ADin;
    end
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < N_REG; i++) e_rdata[8*i +: 8] = model_rdata[i];
    check({tag, " rdata_all"}, 128'(rdata), 128'(e_rdata));
    check({tag, " sb_empty"}, 128'(exp_q.size()), 128'(0));
    check({tag, " done_cnt"}, 128'(dn_cnt), 128'(m_dn));
    check({tag, " err_cnt"}, 128'(er_cnt), 128'(m_er));
    check({tag, " rd_cnt"}, 128'(rd_cnt), 128'(m_rd));
    if (v.exp_done >= 0) check({tag, " done_cycle"}, 128'(dn_cyc), 128'(v.exp_done));
    if (v.exp_err >= 0) check({tag, " err_tab"}, 128'(er_cnt), 128'(v.exp_err));
    if (v.exp_nrd >= 0) check({tag, " nrd_tab"}, 128'(rd_cnt), 128'(v.exp_nrd));
    exp_q.delete();
  endtask

  task automatic run_single();
    logic [7:0] a1, d, e_out;
    a1 = 8'($urandom_range(0, 255));
    addr_tab[7:0] = a1;
    mode = 1'b0; d = 8'h00;
    @(posedge clock);
    #1 start1 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock);
      #1 start1 = 1'b0;
      ADin = 8'($urandom_range(0, 255));
      if (c == 4) d = ADin;
      @(negedge clock);
      e_out = (c <= 2) ? a1 : 8'hFF;
      check($sformatf("single c%0d", c),
            128'({ADout1, ad1, cs1, wr1, rd1, bus_rel1, busy1, done1, err1, rd_valid1, state1 != 3'd0}),
            128'({e_out, single_tab[c-1], single_tab[c-1][3]}));
    end
    check("single rdata", 128'({rd_idx1, rdata1}), 128'({4'h0, d}));
  endtask

  task automatic run_restart();
    int dn_cyc;
    logic [7:0] busy_ad;
    mode = 1'b1; wr_idx = 4'd2; wdata = 8'h5A; dn_cyc = 0; busy_ad = 8'h00;
    @(posedge clock);
    #1 start = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      @(posedge clock);
      #1;
      start = (c <= 46);
      abort = (c == 47);
      @(negedge clock);
      if (done && dn_cyc == 0) dn_cyc = c;
      if (c == 47) busy_ad[3:2] = {busy, ad};
      if (c == 48) busy_ad[1:0] = {busy, ad};
    end
    abort = 1'b0;
    check("restart done_cycle", 128'(dn_cyc), 128'(46));
    check("restart busy_ad", 128'(busy_ad), 128'(8'b0000_1001));
  endtask

  task automatic run_mid_reset();
    int nb, nd;
    mode = 1'b0; nb = 0; nd = 0;
    for (int i = 0; i < N_REG; i++) addr_tab[8*i +: 8] = 8'($urandom_range(0, 255));
    @(posedge clock);
    #1 start = 1'b1;
    for (int c = 1; c <= 190; c++) begin
      @(posedge clock);
      #1;
      ADin = 8'($urandom_range(1, 255));
      if (c == 190) begin reset = 1'b1; abort = 1'b1; end
      @(negedge clock);
      if (busy) nb++;
      if (done) nd++;
    end
    @(posedge clock);
    #1 reset = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clock);
    check_reset_outs("midrst");
    for (int i = 0; i < N_REG; i++) model_rdata[i] = 8'h00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (busy) nb++;
      if (done) nd++;
    end
    check("midrst busy_cycles", 128'(nb), 128'(190));
    check("midrst no_done", 128'(nd), 128'(0));
  endtask

  initial begin
    int span;
    vec_t r;
    reset = 1'b1; start = 1'b0; start1 = 1'b0; mode = 1'b0; abort = 1'b0;
    addr_tab = '0; wr_idx = 4'd0; wdata = 8'h00; ADin = 8'h00;
    do_reset();
    @(negedge clock);
    check_reset_outs("reset");

    vecs.push_back('{1'b0, 4'd0,  8'h00, -1,  0,   1'b1, 451, 0, 10});
    vecs.push_back('{1'b1, 4'd3,  8'h45, -1,  0,   1'b1, 46,  0, 0});
    vecs.push_back('{1'b1, 4'd12, 8'h00, -1,  0,   1'b0, 0,   1, 0});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 100, 0,   1'b0, 0,   0, 2});
    vecs.push_back('{1'b1, 4'd9,  8'hA5, -1,  0,   1'b0, 46,  0, 0});
    vecs.push_back('{1'b1, 4'd10, 8'h00, -1,  0,   1'b0, 0,   1, 0});
    vecs.push_back('{1'b0, 4'd0,  8'h00, -1,  200, 1'b0, 451, 0, 10});
    vecs.push_back('{1'b1, 4'd0,  8'h3C, 30,  0,   1'b0, 0,   0, 0});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 35,  0,   1'b0, 0,   0, 1});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 34,  0,   1'b0, 0,   0, 0});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 0,   0,   1'b0, 0,   0, 0});
    vecs.push_back('{1'b1, 4'd15, 8'h00, -1,  0,   1'b0, 0,   1, 0});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 450, 0,   1'b0, 0,   0, 10});
    for (int i = 0; i < 6; i++) begin
      r.mode = 1'($urandom_range(0, 1));
      r.wr_idx = 4'($urandom_range(0, 15));
      r.wdata = 8'($urandom_range(0, 255));
      r.fixed = 1'b0;
      span = r.mode ? P : N_REG * P;
      r.abort_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, span + 2));
      r.hold = (r.abort_at < 0 && !(r.mode && int'(r.wr_idx) >= N_REG)) ? int'($urandom_range(0, 40)) : 0;
      r.exp_done = -1; r.exp_err = -1; r.exp_nrd = -1;
      vecs.push_back(r);
    end

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], $sformatf("v%0d", i));
    run_single();
    run_restart();
    run_mid_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
